// File: rtl/decoder3_wb.sv
// Wishbone 1-master / 3-slave address decoder with one-cycle request latency and zero-latency ack path.
// Optional ACTIVE-state timeout is compiled in with `define DECODER3_WB_TIMEOUT_EN.
module decoder3_wb #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    SELECT_WIDTH   = DATA_WIDTH/8,
    parameter logic [ADDR_WIDTH-1:0] S0_BASE        = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] S1_BASE        = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] S2_BASE        = 32'h2000_0000,
    parameter logic [ADDR_WIDTH-1:0] S0_MASK        = 32'hF000_0000,
    parameter logic [ADDR_WIDTH-1:0] S1_MASK        = 32'hF000_0000,
    parameter logic [ADDR_WIDTH-1:0] S2_MASK        = 32'hF000_0000,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic                    wbm_stb_i,
    input  logic                    wbm_cyc_i,
    output logic                    wbm_ack_o,
    output logic                    wbm_err_o,
    output logic [ADDR_WIDTH-1:0]   wbs0_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs0_dat_o,
    output logic                    wbs0_we_o,
    output logic [SELECT_WIDTH-1:0] wbs0_sel_o,
    output logic                    wbs0_stb_o,
    output logic                    wbs0_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs0_dat_i,
    input  logic                    wbs0_ack_i,
    output logic [ADDR_WIDTH-1:0]   wbs1_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs1_dat_o,
    output logic                    wbs1_we_o,
    output logic [SELECT_WIDTH-1:0] wbs1_sel_o,
    output logic                    wbs1_stb_o,
    output logic                    wbs1_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs1_dat_i,
    input  logic                    wbs1_ack_i,
    output logic [ADDR_WIDTH-1:0]   wbs2_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs2_dat_o,
    output logic                    wbs2_we_o,
    output logic [SELECT_WIDTH-1:0] wbs2_sel_o,
    output logic                    wbs2_stb_o,
    output logic                    wbs2_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs2_dat_i,
    input  logic                    wbs2_ack_i
);

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

    state_t                state_q, state_d;
    logic [1:0]            sel_q, sel_d;
    logic [2:0]            hit;
    logic [2:0]            slv_cyc;
    logic [2:0]            slv_ack;
    logic [1:0]            win;
    logic                  ack_sel;
    logic [ADDR_WIDTH-1:0] base_a [3];
    logic [ADDR_WIDTH-1:0] mask_a [3];
    logic [DATA_WIDTH-1:0] slv_dat [3];

    assign base_a[0] = S0_BASE;
    assign base_a[1] = S1_BASE;
    assign base_a[2] = S2_BASE;
    assign mask_a[0] = S0_MASK;
    assign mask_a[1] = S1_MASK;
    assign mask_a[2] = S2_MASK;
    assign slv_dat[0] = wbs0_dat_i;
    assign slv_dat[1] = wbs1_dat_i;
    assign slv_dat[2] = wbs2_dat_i;
    assign slv_ack    = {wbs2_ack_i, wbs1_ack_i, wbs0_ack_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slv
            assign hit[gi]     = (wbm_adr_i & mask_a[gi]) == (base_a[gi] & mask_a[gi]);
            assign slv_cyc[gi] = (state_q == ACTIVE) && (sel_q == 2'(gi));
        end
    endgenerate

    // Lowest-numbered slave wins on overlapping windows.
    assign win     = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);
    // Only the granted slave's ack can reach the master; others are masked by slv_cyc.
    assign ack_sel = |(slv_ack & slv_cyc);

    always_comb begin
        wbm_dat_o = '0;
        for (int i = 0; i < 3; i++) begin
            if (slv_cyc[i]) wbm_dat_o = slv_dat[i];
        end
    end

`ifdef DECODER3_WB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wbm_ack_o = 1'b0;
        wbm_err_o = 1'b0;
`ifdef DECODER3_WB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef DECODER3_WB_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (wbm_cyc_i && wbm_stb_i) begin
                    if (|hit) begin
                        sel_d   = win;
                        state_d = ACTIVE;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ACTIVE: begin
                if (!wbm_cyc_i) begin
                    state_d = IDLE;
                end else if (ack_sel) begin
                    wbm_ack_o = 1'b1;
                    state_d   = IDLE;
                end
`ifdef DECODER3_WB_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ERR: begin
                wbm_err_o = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
`ifdef DECODER3_WB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef DECODER3_WB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign wbs0_adr_o = wbm_adr_i;
    assign wbs1_adr_o = wbm_adr_i;
    assign wbs2_adr_o = wbm_adr_i;
    assign wbs0_dat_o = wbm_dat_i;
    assign wbs1_dat_o = wbm_dat_i;
    assign wbs2_dat_o = wbm_dat_i;
    assign wbs0_we_o  = wbm_we_i;
    assign wbs1_we_o  = wbm_we_i;
    assign wbs2_we_o  = wbm_we_i;
    assign wbs0_sel_o = wbm_sel_i;
    assign wbs1_sel_o = wbm_sel_i;
    assign wbs2_sel_o = wbm_sel_i;
    assign wbs0_cyc_o = slv_cyc[0];
    assign wbs1_cyc_o = slv_cyc[1];
    assign wbs2_cyc_o = slv_cyc[2];
    assign wbs0_stb_o = slv_cyc[0] & wbm_stb_i;
    assign wbs1_stb_o = slv_cyc[1] & wbm_stb_i;
    assign wbs2_stb_o = slv_cyc[2] & wbm_stb_i;

endmodule

// File: tb/tb_decoder3_wb.sv
// Directed bench for decoder3_wb: scoreboard of expected master responses checked by a negedge monitor.
module tb_decoder3_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] m_adr = '0, m_wdat = '0;
    logic        m_we = 1'b0, m_stb = 1'b0, m_cyc = 1'b0;
    logic [3:0]  m_sel = '0;
    logic [31:0] m_rdat;
    logic        m_ack, m_err;
    logic [31:0] s_adr [3];
    logic [31:0] s_wdat [3];
    logic [3:0]  s_sel [3];
    logic [31:0] s_rdat [3];
    logic [2:0]  s_we, s_stb, s_cyc;
    logic [2:0]  s_ack = '0;
    logic [31:0] d2_rdat, d2_adr0, d2_adr1, d2_adr2, d2_dat0, d2_dat1, d2_dat2;
    logic        d2_ack, d2_err;
    logic [2:0]  d2_we, d2_stb, d2_cyc;
    logic [3:0]  d2_sel0, d2_sel1, d2_sel2;

    int total = 0;
    int bad   = 0;
    logic [32:0] sb_q [$];

    always #5 clk = ~clk;

    decoder3_wb #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_wdat), .wbm_dat_o(m_rdat), .wbm_we_i(m_we),
        .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_cyc_i(m_cyc), .wbm_ack_o(m_ack), .wbm_err_o(m_err),
        .wbs0_adr_o(s_adr[0]), .wbs0_dat_o(s_wdat[0]), .wbs0_we_o(s_we[0]), .wbs0_sel_o(s_sel[0]),
        .wbs0_stb_o(s_stb[0]), .wbs0_cyc_o(s_cyc[0]), .wbs0_dat_i(s_rdat[0]), .wbs0_ack_i(s_ack[0]),
        .wbs1_adr_o(s_adr[1]), .wbs1_dat_o(s_wdat[1]), .wbs1_we_o(s_we[1]), .wbs1_sel_o(s_sel[1]),
        .wbs1_stb_o(s_stb[1]), .wbs1_cyc_o(s_cyc[1]), .wbs1_dat_i(s_rdat[1]), .wbs1_ack_i(s_ack[1]),
        .wbs2_adr_o(s_adr[2]), .wbs2_dat_o(s_wdat[2]), .wbs2_we_o(s_we[2]), .wbs2_sel_o(s_sel[2]),
        .wbs2_stb_o(s_stb[2]), .wbs2_cyc_o(s_cyc[2]), .wbs2_dat_i(s_rdat[2]), .wbs2_ack_i(s_ack[2])
    );

    // Overlapping windows: slave 1 shares slave 0's base.
    decoder3_wb #(.S1_BASE(32'h0000_0000)) dut2 (
        .clk(clk), .rst(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_wdat), .wbm_dat_o(d2_rdat), .wbm_we_i(m_we),
        .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_cyc_i(m_cyc), .wbm_ack_o(d2_ack), .wbm_err_o(d2_err),
        .wbs0_adr_o(d2_adr0), .wbs0_dat_o(d2_dat0), .wbs0_we_o(d2_we[0]), .wbs0_sel_o(d2_sel0),
        .wbs0_stb_o(d2_stb[0]), .wbs0_cyc_o(d2_cyc[0]), .wbs0_dat_i(32'h0), .wbs0_ack_i(1'b0),
        .wbs1_adr_o(d2_adr1), .wbs1_dat_o(d2_dat1), .wbs1_we_o(d2_we[1]), .wbs1_sel_o(d2_sel1),
        .wbs1_stb_o(d2_stb[1]), .wbs1_cyc_o(d2_cyc[1]), .wbs1_dat_i(32'h0), .wbs1_ack_i(1'b0),
        .wbs2_adr_o(d2_adr2), .wbs2_dat_o(d2_dat2), .wbs2_we_o(d2_we[2]), .wbs2_sel_o(d2_sel2),
        .wbs2_stb_o(d2_stb[2]), .wbs2_cyc_o(d2_cyc[2]), .wbs2_dat_i(32'h0), .wbs2_ack_i(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every ack/err must match the oldest expected response.
    always @(negedge clk) begin
        if (rst && (m_ack || m_err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", {31'd0, m_err, m_ack}, 64'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                chk("resp_err", {63'd0, m_err}, {63'd0, e[32]});
                chk("resp_ack", {63'd0, m_ack}, {63'd0, ~e[32]});
                chk("resp_dat", {32'd0, m_rdat}, {32'd0, e[31:0]});
                $display("resp err=%0b ack=%0b dat=%08h", m_err, m_ack, m_rdat);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] adr, input logic [31:0] wd, input logic we, input logic [3:0] sel);
        m_adr = adr; m_wdat = wd; m_we = we; m_sel = sel; m_cyc = 1'b1; m_stb = 1'b1;
    endtask

    task automatic xfer(input logic [31:0] adr, input logic [31:0] wd, input logic we,
                        input logic [3:0] sel, input int k, input int dly, input logic [31:0] rd,
                        input bit spurious2);
        sb_q.push_back({1'b0, rd});
        step(); drive(adr, wd, we, sel); #1;
        chk("stb_latency", {61'd0, s_stb}, 64'd0);
        step(); #1;
        chk("sel_cyc", {61'd0, s_cyc}, 64'(3'b001 << k));
        chk("sel_stb", {61'd0, s_stb}, 64'(3'b001 << k));
        chk("fwd_adr", {32'd0, s_adr[k]}, {32'd0, adr});
        chk("fwd_dat", {32'd0, s_wdat[k]}, {32'd0, wd});
        chk("fwd_sel", {60'd0, s_sel[k]}, {60'd0, sel});
        chk("fwd_we", {63'd0, s_we[k]}, {63'd0, we});
        for (int i = 0; i < dly; i++) begin
            if (spurious2) s_ack[2] = 1'b1;
            #1;
            chk("no_early_ack", {63'd0, m_ack}, 64'd0);
            step(); s_ack[2] = 1'b0; #1;
        end
        s_rdat[k] = rd; s_ack[k] = 1'b1; #1;
        chk("ack_now", {63'd0, m_ack}, 64'd1);
        step(); s_ack[k] = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; #1;
        chk("cyc_drop", {61'd0, s_cyc}, 64'd0);
        $display("xfer adr=%08h we=%0b slave=%0d rd=%08h", adr, we, k, rd);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) s_rdat[i] = 32'h0;
        #3;
        chk("rst_ack", {63'd0, m_ack}, 64'd0);
        chk("rst_err", {63'd0, m_err}, 64'd0);
        chk("rst_cyc", {61'd0, s_cyc}, 64'd0);
        chk("rst_dat", {32'd0, m_rdat}, 64'd0);
        step(); step(); rst = 1'b1;

        // Read from slave 1, ack two cycles after its strobe
        xfer(32'h1000_0004, 32'h0, 1'b0, 4'hF, 1, 2, 32'hCAFE_F00D, 1'b0);
        // Write to slave 2
        xfer(32'h2000_0010, 32'h1234_5678, 1'b1, 4'b0011, 2, 1, 32'h0000_0000, 1'b0);
        // Slave 2 acks spuriously while slave 0 owns the bus
        xfer(32'h0000_0100, 32'hA5A5_A5A5, 1'b1, 4'b1111, 0, 3, 32'h1111_2222, 1'b1);
        // Immediate ack
        xfer(32'h1FFF_FFFC, 32'h0, 1'b0, 4'hF, 1, 0, 32'hDEAD_BEEF, 1'b0);

        // Unmapped address: one-cycle error, no slave cycle
        sb_q.push_back({1'b1, 32'h0});
        step(); drive(32'h5000_0000, 32'h0, 1'b0, 4'hF); #1;
        chk("err_nocyc0", {61'd0, s_cyc}, 64'd0);
        step(); #1;
        chk("err_pulse", {63'd0, m_err}, 64'd1);
        chk("err_nocyc1", {61'd0, s_cyc}, 64'd0);
        m_cyc = 1'b0; m_stb = 1'b0;
        step(); #1;
        chk("err_gone", {63'd0, m_err}, 64'd0);
        $display("xfer adr=50000000 unmapped");

        // Held strobe after ack is re-decoded as a new transfer
        sb_q.push_back({1'b0, 32'h0000_00AA});
        sb_q.push_back({1'b0, 32'h0000_00BB});
        step(); drive(32'h1000_0000, 32'h0, 1'b0, 4'hF); #1;
        step(); s_rdat[1] = 32'h0000_00AA; s_ack[1] = 1'b1; #1;
        chk("redec_ack1", {63'd0, m_ack}, 64'd1);
        step(); s_ack[1] = 1'b0; #1;
        chk("redec_idle", {61'd0, s_cyc}, 64'd0);
        step(); s_rdat[1] = 32'h0000_00BB; s_ack[1] = 1'b1; #1;
        chk("redec_cyc", {61'd0, s_cyc}, 64'b010);
        chk("redec_ack2", {63'd0, m_ack}, 64'd1);
        step(); s_ack[1] = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; #1;
        $display("xfer held-stb redecode");

        // Overlapping windows resolve to slave 0; master abort gives no response
        step(); drive(32'h0000_0008, 32'h0, 1'b0, 4'hF); #1;
        step(); #1;
        chk("overlap_sel", {61'd0, d2_cyc}, 64'b001);
        m_cyc = 1'b0; m_stb = 1'b0;
        step(); #1;
        chk("abort_cyc", {61'd0, s_cyc}, 64'd0);
        chk("abort_cyc2", {61'd0, d2_cyc}, 64'd0);
        chk("abort_resp", {62'd0, m_ack, m_err}, 64'd0);
        $display("xfer overlap/abort");

`ifdef DECODER3_WB_TIMEOUT_EN
        // Slave 0 never acks: error after 8 ACTIVE cycles
        sb_q.push_back({1'b1, 32'h0});
        step(); drive(32'h0000_0040, 32'h0, 1'b0, 4'hF);
        for (int i = 1; i <= 8; i++) begin
            step(); #1;
            chk("to_wait_err", {63'd0, m_err}, 64'd0);
            chk("to_wait_cyc", {61'd0, s_cyc}, 64'b001);
        end
        step(); #1;
        chk("to_err", {63'd0, m_err}, 64'd1);
        chk("to_cyc_drop", {61'd0, s_cyc}, 64'd0);
        m_cyc = 1'b0; m_stb = 1'b0;
        $display("xfer timeout err");
        // Ack on the 8th ACTIVE cycle wins over timeout
        sb_q.push_back({1'b0, 32'h8888_0008});
        step(); drive(32'h0000_0044, 32'h0, 1'b0, 4'hF);
        for (int i = 1; i < 8; i++) step();
        step(); s_rdat[0] = 32'h8888_0008; s_ack[0] = 1'b1; #1;
        chk("to_ack_wins", {63'd0, m_ack}, 64'd1);
        step(); s_ack[0] = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; #1;
        chk("to_ack_noerr", {63'd0, m_err}, 64'd0);
        $display("xfer timeout ack-wins");
`else
        // No timeout: slave 0 holds the bus indefinitely until the master drops cyc
        step(); drive(32'h0000_0040, 32'h0, 1'b0, 4'hF);
        step();
        for (int i = 0; i < 300; i++) step();
        #1;
        chk("noto_cyc", {61'd0, s_cyc}, 64'b001);
        chk("noto_err", {63'd0, m_err}, 64'd0);
        m_cyc = 1'b0; m_stb = 1'b0;
        step(); #1;
        chk("noto_drop", {61'd0, s_cyc}, 64'd0);
        $display("xfer no-timeout wait");
`endif

        // Reset during ACTIVE drops the slave cycle immediately, no response
        step(); drive(32'h1000_0020, 32'h0, 1'b0, 4'hF);
        step(); #1;
        chk("pre_rst_cyc", {61'd0, s_cyc}, 64'b010);
        s_ack[1] = 1'b1; rst = 1'b0; #1;
        chk("rst_mid_cyc", {61'd0, s_cyc}, 64'd0);
        chk("rst_mid_stb", {61'd0, s_stb}, 64'd0);
        chk("rst_mid_resp", {62'd0, m_ack, m_err}, 64'd0);
        m_cyc = 1'b0; m_stb = 1'b0; s_ack[1] = 1'b0;
        step(); rst = 1'b1;
        step(); step(); #1;
        chk("post_rst_cyc", {61'd0, s_cyc}, 64'd0);
        $display("xfer reset mid-transfer");

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
